// File: rtl/riscv_core_pkg.sv
// Shared core package: default register-file geometry and the register-address type.
package riscv_core_pkg;

  localparam int RF_XLEN  = 64;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  typedef logic [RF_AW-1:0] rf_addr_t;

endpackage

// File: rtl/riscv_core_rf_sb.sv
// Register scoreboard: one busy bit per register, set on long-latency issue,
// cleared by a retiring write. Set wins over clear; entry 0 is never busy.
module riscv_core_rf_sb #(
  parameter int NREGS = 32,
  parameter int NRD   = 3,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWR-1:0]           we,
  input  logic [NWR-1:0][AW-1:0]   wa,
  input  logic [NWR-1:0]           wclr,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_a,
  input  logic [NRD-1:0][AW-1:0]   ra,
  output logic [NREGS-1:0]         busy,
  output logic [NRD-1:0]           rbusy
);

  logic [NREGS-1:0] clr;
  logic [NREGS-1:0] set;
  logic [NREGS-1:0] busy_nxt;

  // Decode this cycle's clear/set requests into per-register vectors
  always_comb begin
    clr = '0;
    set = '0;
    for (int k = 0; k < NWR; k++)
      if (we[k] && wclr[k]) clr[wa[k]] = 1'b1;
    if (sb_set) set[sb_a] = 1'b1;
    busy_nxt    = (busy & ~clr) | set;
    busy_nxt[0] = 1'b0;
  end

  // Per-read-port busy as it will look after the edge; a same-cycle set is not visible yet
  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NRD; i++)
      if (ra[i] != '0) rbusy[i] = clr[ra[i]] ? 1'b0 : busy[ra[i]];
  end

  // Busy vector state; reset drops every pending entry
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/riscv_core_rf_mp.sv
// Multi-ported integer register file: NRD combinational read ports with
// same-cycle write bypass, NWR write ports (highest index wins), x0 hardwired
// to zero, plus a busy scoreboard for long-latency destinations.
module riscv_core_rf_mp
  import riscv_core_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 3,
  parameter int NWR   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                       i_rf_clk,
  input  logic                       i_rf_rst_n,
  input  logic [NRD-1:0][AW-1:0]     i_rf_ra,
  output logic [NRD-1:0][XLEN-1:0]   o_rf_rd,
  output logic [NRD-1:0]             o_rf_rbusy,
  input  logic [NWR-1:0]             i_rf_we,
  input  logic [NWR-1:0][AW-1:0]     i_rf_wa,
  input  logic [NWR-1:0][XLEN-1:0]   i_rf_wd,
  input  logic [NWR-1:0]             i_rf_wclr,
  input  logic                       i_rf_sb_set,
  input  logic [AW-1:0]              i_rf_sb_a,
  output logic [NREGS-1:0]           o_rf_busy
);

  logic [XLEN-1:0] rf [NREGS];

  // Read ports: array value, overridden by a matching same-cycle write (later port wins)
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      o_rf_rd[i] = '0;
      if (i_rf_ra[i] != '0) begin
        o_rf_rd[i] = rf[i_rf_ra[i]];
        for (int k = 0; k < NWR; k++)
          if (i_rf_we[k] && i_rf_wa[k] == i_rf_ra[i]) o_rf_rd[i] = i_rf_wd[k];
      end
    end
  end

  // Data array update; iterating upward lets the highest-index port win a collision
  always_ff @(posedge i_rf_clk) begin
    if (!i_rf_rst_n) begin
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (i_rf_we[k] && i_rf_wa[k] != '0) rf[i_rf_wa[k]] <= i_rf_wd[k];
    end
  end

  riscv_core_rf_sb #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk    (i_rf_clk),
    .rst_n  (i_rf_rst_n),
    .we     (i_rf_we),
    .wa     (i_rf_wa),
    .wclr   (i_rf_wclr),
    .sb_set (i_rf_sb_set),
    .sb_a   (i_rf_sb_a),
    .ra     (i_rf_ra),
    .busy   (o_rf_busy),
    .rbusy  (o_rf_rbusy)
  );

endmodule

// File: tb/tb_riscv_core_rf_mp.sv
// Directed bench for riscv_core_rf_mp: reset, write/read, port priority,
// bypass, scoreboard set/clear rules, x0 handling and mid-operation reset.
module tb_riscv_core_rf_mp;
  import riscv_core_pkg::*;

  localparam int XLEN  = RF_XLEN;
  localparam int NREGS = RF_NREGS;
  localparam int NRD   = 3;
  localparam int NWR   = 2;
  localparam int AW    = RF_AW;

  logic                     clk;
  logic                     rst_n;
  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;
  logic [NRD-1:0]           rbusy;
  logic [NWR-1:0]           we;
  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;
  logic [NWR-1:0]           wclr;
  logic                     sb_set;
  rf_addr_t                 sb_a;
  logic [NREGS-1:0]         busy;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_core_rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .AW(AW)) dut (
    .i_rf_clk    (clk),
    .i_rf_rst_n  (rst_n),
    .i_rf_ra     (ra),
    .o_rf_rd     (rd),
    .o_rf_rbusy  (rbusy),
    .i_rf_we     (we),
    .i_rf_wa     (wa),
    .i_rf_wd     (wd),
    .i_rf_wclr   (wclr),
    .i_rf_sb_set (sb_set),
    .i_rf_sb_a   (sb_a),
    .o_rf_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; wclr = '0; sb_set = 1'b0; sb_a = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    ra = '0;
    tick(); tick();
    rst_n = 1'b1;
    ra[0] = 5'd1; ra[1] = 5'd5; ra[2] = 5'd31;
    #1;
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL reset_busy got %h want 0", busy); end
    for (int i = 0; i < NRD; i++) begin
      n_cmp++; if (rd[i] !== '0) begin n_bad++; $display("FAIL reset_rd%0d got %h want 0", i, rd[i]); end
    end
    n_cmp++; if (rbusy !== '0) begin n_bad++; $display("FAIL reset_rbusy got %b want 0", rbusy); end
  endtask

  task automatic test_write_read();
    idle();
    we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 64'hDEAD_BEEF_0000_0001;
    tick();
    idle();
    ra[0] = 5'd5; ra[1] = 5'd0; ra[2] = 5'd6;
    #1;
    n_cmp++; if (rd[0] !== 64'hDEAD_BEEF_0000_0001) begin n_bad++; $display("FAIL wr_rd_x5 got %h want deadbeef00000001", rd[0]); end
    n_cmp++; if (rd[1] !== '0) begin n_bad++; $display("FAIL wr_rd_x0 got %h want 0", rd[1]); end
    n_cmp++; if (rd[2] !== '0) begin n_bad++; $display("FAIL wr_rd_x6 got %h want 0", rd[2]); end
  endtask

  task automatic test_port_priority();
    idle();
    we = 2'b11; wa[0] = 5'd7; wd[0] = 64'h11; wa[1] = 5'd7; wd[1] = 64'h22;
    ra[0] = 5'd5; ra[1] = 5'd7; ra[2] = 5'd7;
    #1;
    n_cmp++; if (rd[1] !== 64'h22) begin n_bad++; $display("FAIL bypass_hi got %h want 22", rd[1]); end
    n_cmp++; if (rd[0] !== 64'hDEAD_BEEF_0000_0001) begin n_bad++; $display("FAIL bypass_nomatch got %h want deadbeef00000001", rd[0]); end
    tick();
    idle();
    #1;
    n_cmp++; if (rd[2] !== 64'h22) begin n_bad++; $display("FAIL prio_stored got %h want 22", rd[2]); end
    // port0-only bypass on a different register
    we[0] = 1'b1; wa[0] = 5'd8; wd[0] = 64'h88; ra[0] = 5'd8;
    #1;
    n_cmp++; if (rd[0] !== 64'h88) begin n_bad++; $display("FAIL bypass_p0 got %h want 88", rd[0]); end
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set = 1'b1; sb_a = 5'd9; ra[0] = 5'd9;
    #1;
    n_cmp++; if (rbusy[0] !== 1'b0) begin n_bad++; $display("FAIL set_not_visible got %b want 0", rbusy[0]); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy[9] !== 1'b1) begin n_bad++; $display("FAIL sb_set9 got %b want 1", busy[9]); end
    n_cmp++; if (rbusy[0] !== 1'b1) begin n_bad++; $display("FAIL rbusy9 got %b want 1", rbusy[0]); end
    we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 64'h99; wclr[1] = 1'b1;
    #1;
    n_cmp++; if (rbusy[0] !== 1'b0) begin n_bad++; $display("FAIL rbusy_clr got %b want 0", rbusy[0]); end
    n_cmp++; if (busy[9] !== 1'b1) begin n_bad++; $display("FAIL busy_preclr got %b want 1", busy[9]); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy[9] !== 1'b0) begin n_bad++; $display("FAIL busy_clr9 got %b want 0", busy[9]); end
    n_cmp++; if (rd[0] !== 64'h99) begin n_bad++; $display("FAIL clr_data9 got %h want 99", rd[0]); end
    // data write without wclr leaves busy alone
    sb_set = 1'b1; sb_a = 5'd10;
    tick();
    idle();
    we[0] = 1'b1; wa[0] = 5'd10; wd[0] = 64'hA0; ra[1] = 5'd10;
    #1;
    n_cmp++; if (rbusy[1] !== 1'b1) begin n_bad++; $display("FAIL noclr_rbusy got %b want 1", rbusy[1]); end
    tick();
    idle();
    #1;
    n_cmp++; if (busy[10] !== 1'b1) begin n_bad++; $display("FAIL noclr_busy got %b want 1", busy[10]); end
    n_cmp++; if (rd[1] !== 64'hA0) begin n_bad++; $display("FAIL noclr_data got %h want a0", rd[1]); end
  endtask

  task automatic test_set_beats_clear();
    idle();
    sb_set = 1'b1; sb_a = 5'd4;
    we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 64'h4444; wclr[0] = 1'b1;
    tick();
    idle();
    ra[2] = 5'd4;
    #1;
    n_cmp++; if (busy[4] !== 1'b1) begin n_bad++; $display("FAIL setclr_busy got %b want 1", busy[4]); end
    n_cmp++; if (rd[2] !== 64'h4444) begin n_bad++; $display("FAIL setclr_data got %h want 4444", rd[2]); end
  endtask

  task automatic test_x0();
    idle();
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 64'hFF; wclr[0] = 1'b1;
    sb_set = 1'b1; sb_a = 5'd0; ra[0] = 5'd0;
    #1;
    n_cmp++; if (rd[0] !== '0) begin n_bad++; $display("FAIL x0_bypass got %h want 0", rd[0]); end
    n_cmp++; if (rbusy[0] !== 1'b0) begin n_bad++; $display("FAIL x0_rbusy got %b want 0", rbusy[0]); end
    tick();
    idle();
    #1;
    n_cmp++; if (rd[0] !== '0) begin n_bad++; $display("FAIL x0_rd got %h want 0", rd[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL x0_busy got %b want 0", busy[0]); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp [4];
    logic [AW-1:0]   adr [4];
    exp[0] = 64'h0123_4567_89AB_CDEF; adr[0] = 5'd20;
    exp[1] = 64'hFFFF_FFFF_FFFF_FFFF; adr[1] = 5'd31;
    exp[2] = 64'h8000_0000_0000_0000; adr[2] = 5'd1;
    exp[3] = 64'h0000_0000_CAFE_F00D; adr[3] = 5'd21;
    idle();
    for (int c = 0; c < 2; c++) begin
      we = 2'b11;
      wa[0] = adr[2*c]; wd[0] = exp[2*c];
      wa[1] = adr[2*c+1]; wd[1] = exp[2*c+1];
      tick();
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      ra[0] = adr[j];
      #1;
      n_cmp++; if (rd[0] !== exp[j]) begin n_bad++; $display("FAIL b2b_x%0d got %h want %h", adr[j], rd[0], exp[j]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [NREGS-1:0] exp_busy;
    idle();
    sb_set = 1'b1; sb_a = 5'd3;
    we[0] = 1'b1; wa[0] = 5'd12; wd[0] = 64'hC0C0;
    tick();
    sb_a = 5'd12;
    wa[0] = 5'd3; wd[0] = 64'h3333;
    tick();
    idle();
    exp_busy = '0;
    exp_busy[3] = 1'b1; exp_busy[4] = 1'b1; exp_busy[10] = 1'b1; exp_busy[12] = 1'b1;
    #1;
    n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL pre_rst_busy got %h want %h", busy, exp_busy); end
    rst_n = 1'b0;
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 64'h55;
    sb_set = 1'b1; sb_a = 5'd7;
    ra[0] = 5'd3; ra[1] = 5'd12; ra[2] = 5'd20;
    #1;
    n_cmp++; if (rd[0] !== 64'h55) begin n_bad++; $display("FAIL rst_bypass got %h want 55", rd[0]); end
    n_cmp++; if (rd[1] !== 64'hC0C0) begin n_bad++; $display("FAIL rst_arr12 got %h want c0c0", rd[1]); end
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL post_rst_busy got %h want 0", busy); end
    for (int i = 0; i < NRD; i++) begin
      n_cmp++; if (rd[i] !== '0) begin n_bad++; $display("FAIL post_rst_rd%0d got %h want 0", i, rd[i]); end
    end
    n_cmp++; if (rbusy !== '0) begin n_bad++; $display("FAIL post_rst_rbusy got %b want 0", rbusy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_port_priority();
    test_scoreboard();
    test_set_beats_clear();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_core_rf_mp.md
RISCV_CORE_RF_MP -- requirements
Module: riscv_core_rf_mp

Parameters
REQ-001 SHALL have parameter XLEN, default 64: register width in bits.
REQ-002 SHALL have parameter NREGS, default 32: register count; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 3: read port count.
REQ-004 SHALL have parameter NWR, default 2: write port count; index NWR-1 is highest priority.

Interface
REQ-005 SHALL have i_rf_clk, in, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have i_rf_rst_n, in, 1: reset, synchronous, active-low.
REQ-007 SHALL have i_rf_ra, in, NRD x AW: read addresses.
REQ-008 SHALL have o_rf_rd, out, NRD x XLEN: read data.
REQ-009 SHALL have o_rf_rbusy, out, NRD: the register on each read port has a pending write.
REQ-010 SHALL have i_rf_we, in, NWR: write enables.
REQ-011 SHALL have i_rf_wa, in, NWR x AW: write addresses.
REQ-012 SHALL have i_rf_wd, in, NWR x XLEN: write data.
REQ-013 SHALL have i_rf_wclr, in, NWR: this write retires the pending entry (clears busy).
REQ-014 SHALL have i_rf_sb_set, in, 1: issue of a long-latency op; marks i_rf_sb_a busy.
REQ-015 SHALL have i_rf_sb_a, in, AW: destination register being marked busy.
REQ-016 SHALL have o_rf_busy, out, NREGS: full scoreboard vector.

Function
REQ-017 SHALL make reads combinational (zero latency); any read of address 0 returns 0 and rbusy=0.
REQ-018 SHALL write i_rf_wd[k] into rf[i_rf_wa[k]] at the rising edge when i_rf_we[k]=1 and i_rf_wa[k]!=0; writes to address 0 are discarded.
REQ-019 SHALL bypass: a read whose address matches an enabled same-cycle write (address != 0) returns that write data; with multiple matches the highest-index port wins.
REQ-020 SHALL resolve simultaneous writes to the same address in favour of the highest-index port; the lower port's write is dropped.
REQ-021 SHALL set busy[a] at the edge when i_rf_sb_set=1 and a=i_rf_sb_a!=0; setting an already-busy entry leaves it busy.
REQ-022 SHALL clear busy[a] at the edge when any port has we=1, wclr=1, and wa=a.
REQ-023 SHALL let set win over clear for the same register in the same cycle (busy stays 1).
REQ-024 SHALL report o_rf_rbusy[i] as the post-edge value: 0 if a same-cycle clearing write matches, otherwise busy[ra[i]]; a same-cycle set does not yet assert rbusy.
REQ-025 SHALL keep busy[0] permanently 0.
REQ-026 SHALL perform a write with wclr=0 that updates data without touching busy.

Reset
REQ-027 SHALL, on a rising edge with i_rf_rst_n=0, clear every register and every busy bit to 0, ignoring any same-cycle write or set.
REQ-028 SHALL, while in reset, drive o_rf_rd and o_rf_rbusy combinationally from the array and the same-cycle write bypass; o_rf_busy reads all-zero from the first reset edge onward.
REQ-029 SHALL treat reset asserted mid-operation (pending busy entries) identically: all entries drop, and no later wclr is required.

Structure
REQ-030 SHALL take XLEN, NREGS and the register-address typedef from the shared package riscv_core_pkg.
REQ-031 SHALL implement the scoreboard as sub-module riscv_core_rf_sb (set/clear/busy vector); the data array and bypass stay in the top module.

Verification
REQ-032 Reset, then write port0 x5=0xDEAD_BEEF_0000_0001 -> next cycle rd[0](ra=5)=0xDEAD_BEEF_0000_0001; ra=0 -> 0.
REQ-033 Same cycle: port0 x7=0x11 and port1 x7=0x22, rd[1](ra=7) -> bypass 0x22; after edge rf[7]=0x22.
REQ-034 sb_set a=9 -> busy[9]=1 next cycle; write x9 with wclr=1 -> rbusy(ra=9)=0 in the write cycle and busy[9]=0 after the edge.
REQ-035 sb_set a=4 plus write x4 with wclr=1 in the same cycle -> busy[4]=1, rf[4] updated.
REQ-036 Write x0=0xFF with wclr=1, and sb_set a=0 -> rd(ra=0)=0, busy[0]=0.
REQ-037 Set busy on x3 and x12, load data, assert i_rf_rst_n=0 for one cycle with a concurrent write x3=0x55 -> after the edge all registers=0, o_rf_busy=0.
